// File: rtl/fir_seq_pkg.sv
// Shared types and default widths for the FIR RAM sequencer.
package fir_seq_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   localparam int unsigned DefAddrW = 13;
   localparam int unsigned DefInW   = 16;
   localparam int unsigned DefOutW  = 21;
   localparam int unsigned DefNumCh = 2;

endpackage

// File: rtl/fir_skid_reg.sv
// One-entry hold register between the sync-read input RAM and the FIR valid/ready port.
module fir_skid_reg #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         accept_o,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         full_q;
   logic [W-1:0] data_q;

   // Room exists this cycle if empty, or if the held entry leaves on this edge.
   assign accept_o = ~full_q | ready_i;
   assign valid_o  = full_q;
   assign data_o   = data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= load_i | (full_q & ~ready_i);
         if (load_i) begin
            data_q <= data_i;
         end
      end
   end

endmodule

// File: rtl/fir_ram_sequencer.sv
// Arbitrates input/output sample RAMs between the AXI slave and the FIR engine and
// streams one channel's samples through the FIR, writing results back to its output bank.
module fir_ram_sequencer
   import fir_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned IN_W   = DefInW,
   parameter int unsigned OUT_W  = DefOutW,
   parameter int unsigned NUM_CH = DefNumCh,
   // Derived; leave at default.
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic                   a_clk,
   input  logic                   a_rst,
   input  logic                   start,
   input  logic [CH_W-1:0]        ch_sel,
   input  logic [ADDR_W:0]        n_samples,
   output logic                   busy,
   output logic                   done,
   input  logic                   axi_wr,
   input  logic [CH_W+ADDR_W-1:0] axi_addr_wr,
   input  logic [CH_W+ADDR_W-1:0] axi_addr_rd,
   output logic                   axi_wr_drop,
   output logic                   axi_rd_stall,
   output logic [CH_W+ADDR_W-1:0] in_ram_addr,
   output logic                   in_ram_we,
   input  logic [IN_W-1:0]        in_ram_rdata,
   output logic                   fir_valid,
   input  logic                   fir_ready,
   output logic [IN_W-1:0]        fir_sample,
   input  logic                   fir_res_valid,
   input  logic [OUT_W-1:0]       fir_res,
   output logic [CH_W+ADDR_W-1:0] out_ram_addr,
   output logic                   out_ram_we,
   output logic [OUT_W-1:0]       out_ram_wdata
);

   localparam int unsigned CntW = ADDR_W + 1;

   state_t          state_q;
   logic [CH_W-1:0] ch_q;
   logic [CntW-1:0] n_q;
   logic [CntW-1:0] rd_cnt_q;
   logic [CntW-1:0] wr_cnt_q;
   logic            pend_q;
   logic            drop_q;

   logic idle;
   logic hold_accept;
   logic hold_load;
   logic issue;
   logic lost;
   logic res_we;
   logic sent_all;
   logic last_res;

   assign idle         = (state_q == StIdle);
   assign busy         = ~idle;
   assign done         = (state_q == StDone);
   assign axi_rd_stall = busy;
   assign axi_wr_drop  = drop_q;

   always_comb begin
      issue     = (state_q == StRun) && (rd_cnt_q < n_q) && hold_accept;
      hold_load = pend_q & hold_accept;
      // Read data that arrives while the hold reg is stuck is re-fetched later.
      lost      = pend_q & ~hold_accept;
      sent_all  = (rd_cnt_q == n_q) && !pend_q && hold_accept;
      res_we    = fir_res_valid && ((state_q == StRun) || (state_q == StDrain))
                  && (wr_cnt_q < n_q);
      last_res  = (wr_cnt_q == n_q) || (res_we && (wr_cnt_q + CntW'(1) == n_q));

      in_ram_we     = idle & axi_wr;
      in_ram_addr   = idle ? axi_addr_wr : {ch_q, rd_cnt_q[ADDR_W-1:0]};
      out_ram_addr  = idle ? axi_addr_rd : {ch_q, wr_cnt_q[ADDR_W-1:0]};
      out_ram_we    = res_we;
      out_ram_wdata = fir_res;
   end

   fir_skid_reg #(
      .W (IN_W)
   ) u_hold (
      .clk_i    (a_clk),
      .rst_i    (a_rst),
      .load_i   (hold_load),
      .data_i   (in_ram_rdata),
      .ready_i  (fir_ready),
      .accept_o (hold_accept),
      .valid_o  (fir_valid),
      .data_o   (fir_sample)
   );

   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         state_q  <= StIdle;
         ch_q     <= '0;
         n_q      <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         pend_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         drop_q <= axi_wr & ~idle;
         pend_q <= issue;
         if (issue) begin
            rd_cnt_q <= rd_cnt_q + CntW'(1);
         end else if (lost) begin
            rd_cnt_q <= rd_cnt_q - CntW'(1);
         end
         if (res_we) begin
            wr_cnt_q <= wr_cnt_q + CntW'(1);
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  ch_q     <= ch_sel;
                  n_q      <= n_samples;
                  rd_cnt_q <= '0;
                  wr_cnt_q <= '0;
                  state_q  <= (n_samples == '0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (sent_all) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (last_res) begin
                  state_q <= StDone;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_ram_sequencer.sv
// Self-checking bench: RAM and FIR models plus a scoreboard of expected samples and writes.
module tb_fir_ram_sequencer;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned IN_W   = 16;
   localparam int unsigned OUT_W  = 21;
   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CH_W   = 1;
   localparam int unsigned AW     = CH_W + ADDR_W;
   localparam int unsigned DEPTH  = 1 << AW;
   localparam int unsigned CntW   = ADDR_W + 1;

   logic             a_clk = 1'b0;
   logic             a_rst = 1'b1;
   logic             start = 1'b0;
   logic [CH_W-1:0]  ch_sel = '0;
   logic [ADDR_W:0]  n_samples = '0;
   logic             busy, done, axi_wr_drop, axi_rd_stall;
   logic             axi_wr = 1'b0;
   logic [AW-1:0]    axi_addr_wr = '0;
   logic [AW-1:0]    axi_addr_rd = '0;
   logic [AW-1:0]    in_ram_addr, out_ram_addr;
   logic             in_ram_we, fir_valid, out_ram_we;
   logic [IN_W-1:0]  in_ram_rdata;
   logic             fir_ready = 1'b1;
   logic [IN_W-1:0]  fir_sample;
   logic             fir_res_valid = 1'b0;
   logic [OUT_W-1:0] fir_res = '0;
   logic [OUT_W-1:0] out_ram_wdata;

   logic [IN_W-1:0]  axi_wdata = '0;
   logic [IN_W-1:0]  ram  [DEPTH];
   logic [IN_W-1:0]  gold [DEPTH];

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [OUT_W-1:0] data;
   } wr_t;

   typedef struct {
      logic          wr;
      logic [AW-1:0] aw;
      logic [AW-1:0] ar;
      logic          exp_we;
      logic [AW-1:0] exp_in;
      logic [AW-1:0] exp_out;
   } vec_t;

   logic [IN_W-1:0] exp_smp[$];
   wr_t             exp_wr[$];
   vec_t            vt[4];

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int valid_seen = 0;
   int we_seen = 0;
   int xfer_seen = 0;
   int ready_mode = 0;

   fir_ram_sequencer #(
      .ADDR_W (ADDR_W),
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .NUM_CH (NUM_CH)
   ) dut (
      .a_clk         (a_clk),
      .a_rst         (a_rst),
      .start         (start),
      .ch_sel        (ch_sel),
      .n_samples     (n_samples),
      .busy          (busy),
      .done          (done),
      .axi_wr        (axi_wr),
      .axi_addr_wr   (axi_addr_wr),
      .axi_addr_rd   (axi_addr_rd),
      .axi_wr_drop   (axi_wr_drop),
      .axi_rd_stall  (axi_rd_stall),
      .in_ram_addr   (in_ram_addr),
      .in_ram_we     (in_ram_we),
      .in_ram_rdata  (in_ram_rdata),
      .fir_valid     (fir_valid),
      .fir_ready     (fir_ready),
      .fir_sample    (fir_sample),
      .fir_res_valid (fir_res_valid),
      .fir_res       (fir_res),
      .out_ram_addr  (out_ram_addr),
      .out_ram_we    (out_ram_we),
      .out_ram_wdata (out_ram_wdata)
   );

   always #5 a_clk = ~a_clk;

   function automatic logic [OUT_W-1:0] fir_f(input logic [IN_W-1:0] s);
      return {s, 5'h15};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronous-read input RAM, written only through the DUT's muxed port.
   always @(posedge a_clk) begin
      if (in_ram_we) ram[in_ram_addr] <= axi_wdata;
      in_ram_rdata <= ram[in_ram_addr];
   end

   initial begin
      forever begin
         @(posedge a_clk);
         #1;
         case (ready_mode)
            0:       fir_ready = 1'b1;
            1:       fir_ready = ~fir_ready;
            2:       fir_ready = 1'b0;
            default: fir_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // FIR echo model: fixed 3-stage latency, no backpressure.
   initial begin
      logic [2:0]      pv;
      logic [OUT_W-1:0] pd [3];
      logic            x;
      logic [IN_W-1:0] s;
      pv = '0;
      for (int i = 0; i < 3; i++) pd[i] = '0;
      forever begin
         @(negedge a_clk);
         x = fir_valid & fir_ready & ~a_rst;
         s = fir_sample;
         @(posedge a_clk);
         #1;
         pv    = {pv[1:0], x};
         pd[2] = pd[1];
         pd[1] = pd[0];
         pd[0] = fir_f(s);
         fir_res_valid = pv[2];
         fir_res       = pd[2];
      end
   end

   // Monitor: scoreboard pops and stall-stability checks.
   initial begin
      logic            stall_q;
      logic [IN_W-1:0] stall_smp;
      stall_q = 1'b0;
      stall_smp = '0;
      forever begin
         @(negedge a_clk);
         if (a_rst) begin
            stall_q = 1'b0;
         end else begin
            if (fir_valid) valid_seen++;
            if (done) done_seen++;
            if (stall_q) begin
               chk("stall_valid", 64'(fir_valid), 64'd1);
               chk("stall_sample", 64'(fir_sample), 64'(stall_smp));
            end
            stall_q   = fir_valid & ~fir_ready;
            stall_smp = fir_sample;
            if (fir_valid && fir_ready) begin
               xfer_seen++;
               if (exp_smp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_sample: got %0h, none expected", fir_sample);
               end else begin
                  chk("sample", 64'(fir_sample), 64'(exp_smp.pop_front()));
               end
            end
            if (out_ram_we) begin
               we_seen++;
               if (exp_wr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                           out_ram_addr, out_ram_wdata);
               end else begin
                  wr_t e;
                  e = exp_wr.pop_front();
                  chk("wr_addr", 64'(out_ram_addr), 64'(e.addr));
                  chk("wr_data", 64'(out_ram_wdata), 64'(e.data));
               end
            end
         end
      end
   end

   task automatic start_job(input logic [CH_W-1:0] ch, input int n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] a;
         a = {ch, ADDR_W'(i)};
         exp_smp.push_back(gold[a]);
         exp_wr.push_back('{addr: a, data: fir_f(gold[a])});
      end
      @(posedge a_clk);
      #1;
      start     = 1'b1;
      ch_sel    = ch;
      n_samples = CntW'(n);
      @(posedge a_clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc;
      int d0;
      cyc = 0;
      d0  = done_seen;
      while (!done && cyc < 400) begin
         @(negedge a_clk);
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: done not seen after %0d cycles, required within 400", name, cyc);
      end else begin
         @(negedge a_clk);
         chk({name, "_busy_after_done"}, 64'(busy), 64'd0);
         chk({name, "_done_width"}, 64'(done), 64'd0);
         chk({name, "_done_count"}, 64'(done_seen - d0), 64'd1);
         chk({name, "_samples_left"}, 64'(exp_smp.size()), 64'd0);
         chk({name, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required < 200000 time units");
      $fatal(1);
   end

   initial begin
      int d0;
      int v0;
      int w0;
      int cyc;

      vt[0] = '{wr: 1'b1, aw: 5'd21, ar: 5'd3,  exp_we: 1'b1, exp_in: 5'd21, exp_out: 5'd3};
      vt[1] = '{wr: 1'b0, aw: 5'd7,  ar: 5'd18, exp_we: 1'b0, exp_in: 5'd7,  exp_out: 5'd18};
      vt[2] = '{wr: 1'b1, aw: 5'd31, ar: 5'd0,  exp_we: 1'b1, exp_in: 5'd31, exp_out: 5'd0};
      vt[3] = '{wr: 1'b1, aw: 5'd0,  ar: 5'd31, exp_we: 1'b1, exp_in: 5'd0,  exp_out: 5'd31};
      for (int a = 0; a < int'(DEPTH); a++) gold[a] = IN_W'(32'h9E37 * (a + 1));

      repeat (3) @(posedge a_clk);
      #1 a_rst = 1'b0;

      // Reset state
      @(negedge a_clk);
      chk("rst_outputs", 64'({busy, done, fir_valid, out_ram_we, in_ram_we, axi_wr_drop}), 64'd0);

      // Idle AXI routing table
      for (int i = 0; i < 4; i++) begin
         @(posedge a_clk);
         #1;
         axi_wr      = vt[i].wr;
         axi_addr_wr = vt[i].aw;
         axi_addr_rd = vt[i].ar;
         @(negedge a_clk);
         chk($sformatf("idle_we_%0d", i), 64'(in_ram_we), 64'(vt[i].exp_we));
         chk($sformatf("idle_in_addr_%0d", i), 64'(in_ram_addr), 64'(vt[i].exp_in));
         chk($sformatf("idle_out_addr_%0d", i), 64'(out_ram_addr), 64'(vt[i].exp_out));
         chk($sformatf("idle_no_drop_%0d", i), 64'(axi_wr_drop), 64'd0);
      end

      // Load input RAM through the idle AXI path
      for (int a = 0; a < int'(DEPTH); a++) begin
         @(posedge a_clk);
         #1;
         axi_wr      = 1'b1;
         axi_addr_wr = AW'(a);
         axi_wdata   = gold[a];
      end
      @(posedge a_clk);
      #1 axi_wr = 1'b0;

      // ch1 n=4, ready high, first valid two edges after start
      ready_mode = 0;
      start_job(1'b1, 4);
      @(negedge a_clk);
      chk("lat_cycle1", 64'(fir_valid), 64'd0);
      chk("busy_in_run", 64'(busy), 64'd1);
      @(negedge a_clk);
      chk("lat_cycle2", 64'(fir_valid), 64'd0);
      @(negedge a_clk);
      chk("lat_cycle3", 64'(fir_valid), 64'd1);
      wait_done("ch1_n4");

      // ch0 n=8, ready toggling
      ready_mode = 1;
      start_job(1'b0, 8);
      wait_done("ch0_n8_toggle");
      ready_mode = 0;

      // n=0: immediate done
      v0 = valid_seen;
      w0 = we_seen;
      start_job(1'b1, 0);
      @(negedge a_clk);
      chk("n0_done", 64'(done), 64'd1);
      chk("n0_busy", 64'(busy), 64'd1);
      @(negedge a_clk);
      chk("n0_done_gone", 64'({busy, done}), 64'd0);
      chk("n0_no_valid", 64'(valid_seen - v0), 64'd0);
      chk("n0_no_write", 64'(we_seen - w0), 64'd0);

      // AXI write and second start during RUN
      start_job(1'b0, 8);
      repeat (2) @(posedge a_clk);
      #1;
      axi_wr      = 1'b1;
      axi_addr_wr = 5'd19;
      axi_wdata   = 16'hDEAD;
      start       = 1'b1;
      ch_sel      = 1'b1;
      n_samples   = CntW'(2);
      @(negedge a_clk);
      chk("run_in_we", 64'(in_ram_we), 64'd0);
      chk("run_rd_stall", 64'(axi_rd_stall), 64'd1);
      @(posedge a_clk);
      #1;
      axi_wr = 1'b0;
      start  = 1'b0;
      @(negedge a_clk);
      chk("run_drop_pulse", 64'(axi_wr_drop), 64'd1);
      @(negedge a_clk);
      chk("run_drop_width", 64'(axi_wr_drop), 64'd0);
      wait_done("ch0_n8_ignored_start");
      chk("ram_not_written", 64'(ram[19]), 64'(gold[19]));

      // Reset mid-run, then restart
      d0 = xfer_seen;
      start_job(1'b1, 8);
      cyc = 0;
      while (xfer_seen - d0 < 3 && cyc < 100) begin
         @(negedge a_clk);
         cyc++;
      end
      chk("mid_run_progress", 64'(xfer_seen - d0 >= 3), 64'd1);
      #1 a_rst = 1'b1;
      #1;
      chk("rst_async_outs", 64'({busy, done, fir_valid, out_ram_we}), 64'd0);
      exp_smp.delete();
      exp_wr.delete();
      @(posedge a_clk);
      @(posedge a_clk);
      #1 a_rst = 1'b0;
      d0 = done_seen;
      repeat (6) @(negedge a_clk);
      chk("no_done_after_rst", 64'(done_seen - d0), 64'd0);
      chk("idle_after_rst", 64'(busy), 64'd0);
      start_job(1'b1, 8);
      wait_done("restart_ch1_n8");

      // Full bank, must not wrap into ch1
      start_job(1'b0, 16);
      wait_done("ch0_full_bank");

      // Random backpressure
      ready_mode = 3;
      start_job(1'b1, 10);
      wait_done("ch1_n10_random");
      ready_mode = 0;

      repeat (4) @(posedge a_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
